// File: rtl/spi_flash_writer.sv
// SPI mode-0 flash programmer: WRITE ENABLE, PAGE PROGRAM of one byte, optional status polling.
// Define SPI_WRITER_POLL_EN to compile in the READ STATUS poll loop (GAP2/POLL/CHECK).
module spi_flash_writer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_POLLS  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic       cs,
    output logic       busy,
    output logic       done,
    output logic [7:0] status,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_GAP1,
        S_PROG,
        S_GAP2,
        S_POLL,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
`ifdef SPI_WRITER_POLL_EN
    localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);
`endif

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [5:0]  half_q, half_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] poll_q, poll_d;
    logic [7:0]  status_q, status_d;
    logic        err_q, err_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        in_frame_s;
    logic [5:0]  last_half_s;
    logic        frame_end_s;

    // Frame geometry: a frame is 2*bits+2 half-phases (setup, bits high/low, hold).
    always_comb begin
        in_frame_s  = 1'b0;
        last_half_s = 6'd0;
        case (state_q)
            S_WREN: begin
                in_frame_s  = 1'b1;
                last_half_s = 6'd17;
            end
            S_PROG: begin
                in_frame_s  = 1'b1;
                last_half_s = 6'd49;
            end
            S_POLL: begin
                in_frame_s  = 1'b1;
                last_half_s = 6'd33;
            end
            default: begin
                in_frame_s  = 1'b0;
                last_half_s = 6'd0;
            end
        endcase
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        half_d      = half_q;
        gap_d       = gap_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        poll_d      = poll_q;
        status_d    = status_q;
        err_d       = err_q;
        frame_end_s = 1'b0;

        if (in_frame_s) begin
            if (div_q == DIV_LAST) begin
                div_d = 16'd0;
                if (half_q == last_half_s) begin
                    frame_end_s = 1'b1;
                end else begin
                    half_d = half_q + 6'd1;
                    // Leaving a high phase: next bit appears at the start of the low phase.
                    if (half_q[0]) begin
                        shift_d = {shift_q[30:0], 1'b0};
                    end else begin
                        shift_d = shift_q;
                    end
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end else begin
            frame_end_s = 1'b0;
        end

`ifdef SPI_WRITER_POLL_EN
        // Read byte occupies bits 8..15 of the poll frame; sample as sclk rises.
        if (state_q == S_POLL && half_q[0] && div_q == 16'd0 &&
            half_q != last_half_s && half_q[5:1] >= 5'd8) begin
            rx_d = {rx_q[6:0], miso};
        end else begin
            rx_d = rx_q;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = address;
                    data_d  = data_in;
                    err_d   = 1'b0;
                    poll_d  = 16'd0;
                    div_d   = 16'd0;
                    half_d  = 6'd0;
                    shift_d = {8'h06, 24'h000000};
                    state_d = S_WREN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WREN: begin
                if (frame_end_s) begin
                    gap_d   = 16'd0;
                    state_d = S_GAP1;
                end else begin
                    state_d = S_WREN;
                end
            end
            S_PROG: begin
                if (frame_end_s) begin
`ifdef SPI_WRITER_POLL_EN
                    gap_d   = 16'd0;
                    state_d = S_GAP2;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_PROG;
                end
            end
            S_GAP1, S_GAP2: begin
                if (gap_q == GAP_LAST) begin
                    div_d  = 16'd0;
                    half_d = 6'd0;
                    if (state_q == S_GAP1) begin
                        shift_d = {8'h02, addr_q, data_q, 8'h00};
                        state_d = S_PROG;
                    end else begin
                        shift_d = {8'h05, 24'h000000};
                        state_d = S_POLL;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`ifdef SPI_WRITER_POLL_EN
            S_POLL: begin
                if (frame_end_s) begin
                    poll_d  = poll_q + 16'd1;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_POLL;
                end
            end
            S_CHECK: begin
                status_d = rx_q;
                if (!rx_q[0]) begin
                    state_d = S_DONE;
                end else if (poll_q < POLL_LIMIT) begin
                    gap_d   = 16'd0;
                    state_d = S_GAP2;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pins are decoded from the current state, so cs falls one edge after accept.
        cs_d   = ~in_frame_s;
        sclk_d = in_frame_s & half_q[0] & (half_q != last_half_s);
        mosi_d = in_frame_s & shift_q[31];
        busy_d = (state_q != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= 16'd0;
            half_q   <= 6'd0;
            gap_q    <= 16'd0;
            shift_q  <= 32'h00000000;
            rx_q     <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            poll_q   <= 16'd0;
            status_q <= 8'h00;
            err_q    <= 1'b0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            half_q   <= half_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            rx_q     <= rx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            poll_q   <= poll_d;
            status_q <= status_d;
            err_q    <= err_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cs   = cs_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef SPI_WRITER_POLL_EN
    assign status = status_q;
    assign err    = err_q;
`else
    logic unused_ok;
    assign unused_ok = ^{miso, 16'(MAX_POLLS)};
    assign status    = 8'h00;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_writer.sv
// Directed bench for spi_flash_writer with a behavioural SPI flash responder.
// Poll-specific scenarios compile in when SPI_WRITER_POLL_EN is defined.
module tb_spi_flash_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       miso = 1'b0;
    logic       mosi, sclk, cs, busy, done, err;
    logic [7:0] status;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SPI_WRITER_POLL_EN
    localparam int EXTRA_FRAMES = 1;
`else
    localparam int EXTRA_FRAMES = 0;
`endif

    spi_flash_writer #(.CLK_DIV(2), .GAP_CYCLES(4), .MAX_POLLS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .address(address), .data_in(data_in),
        .miso(miso), .mosi(mosi), .sclk(sclk), .cs(cs), .busy(busy), .done(done),
        .status(status), .err(err)
    );

    always #5 clk = ~clk;

    // Flash responder: capture mosi on sclk rise, drive status bits on sclk fall.
    logic [31:0] sh = 32'h0;
    logic [5:0]  bit_cnt = 6'd0;
    int          poll_total = 0;
    int          poll_base = 0;
    int          resp_idx;
    logic [7:0]  resp_tab [8];
    logic [7:0]  resp_byte;
    int          fr_bits [$];
    logic [31:0] fr_val [$];
    int          done_cnt = 0;

    assign resp_idx  = ((poll_total - poll_base) > 7) ? 7 : (poll_total - poll_base);
    assign resp_byte = resp_tab[resp_idx[2:0]];

    always @(negedge cs or posedge sclk) begin
        if (sclk === 1'b1) begin
            sh      <= {sh[30:0], mosi};
            bit_cnt <= bit_cnt + 6'd1;
        end else begin
            sh      <= 32'h0;
            bit_cnt <= 6'd0;
        end
    end

    always @(negedge sclk) begin
        if (bit_cnt >= 6'd8 && bit_cnt < 6'd16) miso <= resp_byte[3'd7 - bit_cnt[2:0]];
    end

    always @(posedge cs) begin
        if (bit_cnt != 6'd0) begin
            fr_bits.push_back(int'(bit_cnt));
            fr_val.push_back(sh);
            if (bit_cnt == 6'd16) poll_total <= poll_total + 1;
        end
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int fall_e [$];
    int rise_e [$];
    int done_edge, done_base;
    logic busy_at_done, busy_after;

    task automatic run_op(input logic [7:0] a, input logic [7:0] d, input int extra_start,
                          input int rst_at, input int limit);
        logic prev_cs;
        fr_bits.delete(); fr_val.delete(); fall_e.delete(); rise_e.delete();
        done_base = done_cnt;
        poll_base = poll_total;
        done_edge = 0;
        busy_at_done = 1'b0;
        busy_after = 1'b1;
        @(negedge clk);
        address = a; data_in = d; start = 1'b1;
        prev_cs = cs;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cs !== prev_cs) begin
                if (cs === 1'b0) fall_e.push_back(k);
                else rise_e.push_back(k);
            end
            prev_cs = cs;
            if (done === 1'b1 && done_edge == 0) begin
                done_edge = k;
                busy_at_done = busy;
            end
            if (done_edge != 0 && k == done_edge + 1) begin
                busy_after = busy;
                break;
            end
            if (rst_at > 0 && k == rst_at + 1) begin
                n_checks += 7;
                if (cs !== 1'b1) begin n_fail++; $display("FAIL abort_cs: got %b want 1", cs); end
                if (sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b want 0", sclk); end
                if (mosi !== 1'b0) begin n_fail++; $display("FAIL abort_mosi: got %b want 0", mosi); end
                if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
                if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
                if (status !== 8'h00) begin n_fail++; $display("FAIL abort_status: got %h want 00", status); end
                if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b want 0", err); end
            end
            if (rst_at > 0 && k == rst_at + 2) rst = 1'b0;
            if (rst_at > 0 && k == rst_at + 12) break;
            if (k == extra_start) start = 1'b1;
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
        end
        if (rst_at == 0) begin
            n_checks++;
            if (done_edge == 0) begin n_fail++; $display("FAIL done_timeout: no done within %0d cycles", limit); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks += 7;
        if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs); end
        if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", status); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_write();
        for (int i = 0; i < 8; i++) resp_tab[i] = 8'h00;
        run_op(8'h0A, 8'h5A, 0, 0, 600);
        n_checks += 2;
        if (fr_bits.size() != 2 + EXTRA_FRAMES) begin
            n_fail++; $display("FAIL write_nframes: got %0d want %0d", fr_bits.size(), 2 + EXTRA_FRAMES);
        end
        if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL write_ndone: got %0d want 1", done_cnt - done_base); end
        if (fr_bits.size() >= 2) begin
            n_checks += 3;
            if (fr_bits[0] != 8 || fr_val[0] !== 32'h00000006) begin
                n_fail++; $display("FAIL write_wren: got %0d bits %h want 8 bits 00000006", fr_bits[0], fr_val[0]);
            end
            if (fr_bits[1] != 24) begin n_fail++; $display("FAIL write_prog_len: got %0d want 24", fr_bits[1]); end
            if (fr_val[1] !== 32'h00020A5A) begin n_fail++; $display("FAIL write_prog: got %h want 00020a5a", fr_val[1]); end
        end
`ifndef SPI_WRITER_POLL_EN
        n_checks += 4;
        if (fall_e.size() != 2 || rise_e.size() != 2) begin
            n_fail++; $display("FAIL write_cs_edges: got %0d falls %0d rises want 2 2", fall_e.size(), rise_e.size());
        end else begin
            if (fall_e[0] != 1 || rise_e[0] != 37) begin
                n_fail++; $display("FAIL write_wren_window: got %0d..%0d want 1..37", fall_e[0], rise_e[0]);
            end
            if (fall_e[1] != 41 || rise_e[1] != 141) begin
                n_fail++; $display("FAIL write_prog_window: got %0d..%0d want 41..141", fall_e[1], rise_e[1]);
            end
        end
        if (done_edge != 141) begin n_fail++; $display("FAIL write_latency: got %0d want 141", done_edge); end
        if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
            n_fail++; $display("FAIL write_busy: got %b then %b want 1 then 0", busy_at_done, busy_after);
        end
`endif
        n_checks += 2;
        if (status !== 8'h00) begin n_fail++; $display("FAIL write_status: got %h want 00", status); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", err); end
    endtask

    task automatic test_start_ignored();
        int lows;
        for (int i = 0; i < 8; i++) resp_tab[i] = 8'h00;
        run_op(8'h33, 8'hC3, 60, 0, 600);
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (cs === 1'b0) lows++;
        end
        n_checks += 3;
        if (fr_bits.size() != 2 + EXTRA_FRAMES) begin
            n_fail++; $display("FAIL ignore_nframes: got %0d want %0d", fr_bits.size(), 2 + EXTRA_FRAMES);
        end else if (fr_val[1] !== 32'h000233C3) begin
            n_fail++; $display("FAIL ignore_prog: got %h want 000233c3", fr_val[1]);
        end
        if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL ignore_ndone: got %0d want 1", done_cnt - done_base); end
        if (lows != 0) begin n_fail++; $display("FAIL ignore_restart: got %0d cs-low cycles want 0", lows); end
    endtask

`ifdef SPI_WRITER_POLL_EN
    task automatic test_poll_seq();
        resp_tab[0] = 8'h01; resp_tab[1] = 8'h01; resp_tab[2] = 8'h00;
        for (int i = 3; i < 8; i++) resp_tab[i] = 8'h00;
        run_op(8'h10, 8'h20, 0, 0, 1000);
        n_checks += 4;
        if (fr_bits.size() != 5) begin
            n_fail++; $display("FAIL poll_nframes: got %0d want 5", fr_bits.size());
        end else if (fr_bits[4] != 16 || fr_val[4] !== 32'h00000500) begin
            n_fail++; $display("FAIL poll_frame: got %0d bits %h want 16 bits 00000500", fr_bits[4], fr_val[4]);
        end
        if (status !== 8'h00) begin n_fail++; $display("FAIL poll_status: got %h want 00", status); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL poll_err: got %b want 0", err); end
        if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL poll_ndone: got %0d want 1", done_cnt - done_base); end
    endtask

    task automatic test_poll_timeout();
        for (int i = 0; i < 8; i++) resp_tab[i] = 8'h03;
        run_op(8'h44, 8'h55, 0, 0, 1000);
        n_checks += 4;
        if (fr_bits.size() != 5) begin n_fail++; $display("FAIL timeout_nframes: got %0d want 5", fr_bits.size()); end
        if (status !== 8'h03) begin n_fail++; $display("FAIL timeout_status: got %h want 03", status); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
        if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL timeout_ndone: got %0d want 1", done_cnt - done_base); end
    endtask
`endif

    task automatic test_rst_abort();
        for (int i = 0; i < 8; i++) resp_tab[i] = 8'h00;
        // Edge 84 falls inside PROG bit 10 high phase at the default timing.
        run_op(8'h77, 8'h88, 0, 84, 600);
        n_checks += 1;
        if (done_cnt - done_base != 0) begin n_fail++; $display("FAIL abort_ndone: got %0d want 0", done_cnt - done_base); end
        run_op(8'h0B, 8'hA5, 0, 0, 600);
        n_checks += 2;
        if (fr_bits.size() != 2 + EXTRA_FRAMES) begin
            n_fail++; $display("FAIL after_nframes: got %0d want %0d", fr_bits.size(), 2 + EXTRA_FRAMES);
        end else if (fr_val[0] !== 32'h00000006 || fr_val[1] !== 32'h00020BA5) begin
            n_fail++; $display("FAIL after_frames: got %h %h want 00000006 00020ba5", fr_val[0], fr_val[1]);
        end
        if (done_cnt - done_base != 1) begin n_fail++; $display("FAIL after_ndone: got %0d want 1", done_cnt - done_base); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) resp_tab[i] = 8'h00;
        test_reset();
        test_write();
        test_start_ignored();
`ifdef SPI_WRITER_POLL_EN
        test_poll_seq();
        test_poll_timeout();
`endif
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
